// File: rtl/vmm_pkg.sv
// ============================================================================
// Module      : vmm_pkg
// Description : Shared definitions for the VMM engine, the result BCD
//               converter and the display top: default datapath widths and
//               the result-converter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vmm_pkg;

  // Default widths shared by the VMM, the BCD converter and the display top.
  localparam int VMM_W  = 8;   // binary result width
  localparam int VMM_D  = 3;   // BCD digits; 10**VMM_D must exceed 2**VMM_W
  localparam int VMM_IW = 5;   // row/column index width

  // Result converter states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,  // wait for a new result
    SHIFT    = 2'd1,  // run the shift-add-3 loop
    PUBLISH  = 2'd2,  // update the published outputs
    WAIT_LOW = 2'd3   // wait for upstream to release next_i
  } bcd_state_t;

endpackage : vmm_pkg

`default_nettype wire

// File: rtl/vmm_result_bcd_if.sv
// ============================================================================
// Module      : vmm_result_bcd_if
// Description : Handshake and result bus between the VMM engine (master) and
//               the result BCD converter (slave).
//   Master drives : next_i, val_i[W], i_i[IW], j_i[IW]
//   Slave drives  : done_o, busy_o, valid_o, bcd_o[4*D], sign_o,
//                   i_o[IW], j_o[IW]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vmm_result_bcd_if
  import vmm_pkg::*;
#(
  parameter int W  = VMM_W,
  parameter int D  = VMM_D,
  parameter int IW = VMM_IW
);

  // Upstream request side
  logic            next_i;   // result valid, level, held until done_o
  logic [W-1:0]    val_i;    // binary result (vmm_out)
  logic [IW-1:0]   i_i;      // row index
  logic [IW-1:0]   j_i;      // column index

  // Converter response side
  logic            done_o;   // one-cycle completion pulse
  logic            busy_o;   // conversion in progress
  logic            valid_o;  // at least one result published
  logic [4*D-1:0]  bcd_o;    // packed BCD, digit 0 in [3:0]
  logic            sign_o;   // sign of the published value
  logic [IW-1:0]   i_o;      // published row index
  logic [IW-1:0]   j_o;      // published column index

  modport master (
    output next_i, val_i, i_i, j_i,
    input  done_o, busy_o, valid_o, bcd_o, sign_o, i_o, j_o
  );

  modport slave (
    input  next_i, val_i, i_i, j_i,
    output done_o, busy_o, valid_o, bcd_o, sign_o, i_o, j_o
  );

endinterface : vmm_result_bcd_if

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module      : bcd_digit_adj
// Description : Single-digit double-dabble adjust. Adds 3 to a BCD digit
//               that is 5 or more so that the following left shift carries
//               correctly into the next decimal digit.
//   i_digit [3:0] : scratch digit before adjust
//   o_digit [3:0] : adjusted digit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj (
  input  wire logic [3:0] i_digit,
  output logic      [3:0] o_digit
);

  // Digits never exceed 9 before adjust, so the sum fits in 4 bits.
  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_digit_adj

`default_nettype wire

// File: rtl/vmm_result_bcd.sv
// ============================================================================
// Module      : vmm_result_bcd
// Description : Result latch and sequential binary-to-BCD converter placed
//               after the VMM engine. Captures one result with its indices,
//               converts it with W shift-add-3 cycles, publishes it for the
//               display path and returns a one-cycle done pulse.
//   vmm_clk : block clock (divided design clock shared with the VMM)
//   rst_    : asynchronous active-low reset
//   bus     : vmm_result_bcd_if.slave
//             in  next_i, val_i[W], i_i[IW], j_i[IW]
//             out done_o, busy_o, valid_o, bcd_o[4*D], sign_o, i_o, j_o
// Build option : VMM_BCD_SIGNED_EN - treat val_i as two's complement,
//                convert the magnitude and publish the sign on sign_o.
//                Undefined: val_i unsigned and sign_o tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vmm_result_bcd
  import vmm_pkg::*;
#(
  parameter int W  = VMM_W,
  parameter int D  = VMM_D,
  parameter int IW = VMM_IW
) (
  input  wire logic        vmm_clk,
  input  wire logic        rst_,
  vmm_result_bcd_if.slave  bus
);

  // Shift counter must hold the value W.
  localparam int CNT_W = $clog2(W + 1);
  localparam int BCD_W = 4 * D;

  // --------------------------------------------------------------------------
  // State and working registers
  // --------------------------------------------------------------------------
  bcd_state_t         r_state;
  bcd_state_t         w_state_nxt;

  logic [W-1:0]       r_bin;      // binary value being shifted out
  logic [BCD_W-1:0]   r_scr;      // BCD scratch being built
  logic [CNT_W-1:0]   r_cnt;      // remaining shift cycles
  logic [IW-1:0]      r_i_lat;
  logic [IW-1:0]      r_j_lat;

  // Published outputs
  logic               r_done;
  logic               r_valid;
  logic [BCD_W-1:0]   r_bcd;
  logic [IW-1:0]      r_i_pub;
  logic [IW-1:0]      r_j_pub;

  // FSM decode strobes
  logic               w_load;
  logic               w_shift;
  logic               w_publish;

  // Datapath wires
  logic [W-1:0]       w_mag;
  logic [BCD_W-1:0]   w_scr_adj;
  logic [BCD_W+W-1:0] w_shifted;

  // --------------------------------------------------------------------------
  // Input magnitude and sign
  // --------------------------------------------------------------------------
`ifdef VMM_BCD_SIGNED_EN
  logic w_neg;
  logic r_sign_lat;
  logic r_sign_pub;

  // Two's complement negate; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude (e.g. -128 -> 128).
  assign w_neg = bus.val_i[W-1];
  assign w_mag = w_neg ? (~bus.val_i + W'(1)) : bus.val_i;
`else
  assign w_mag = bus.val_i;
`endif

  // --------------------------------------------------------------------------
  // Per-digit add-3 adjust, no carry between digits
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < D; g++) begin : g_digit
    bcd_digit_adj u_adj (
      .i_digit (r_scr[4*g +: 4]),
      .o_digit (w_scr_adj[4*g +: 4])
    );
  end

  // Adjust first, then shift {scratch, bin} left by one.
  assign w_shifted = {w_scr_adj, r_bin} << 1;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge vmm_clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and decode strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_publish   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.next_i) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        // The shift performed this cycle is the last one.
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = PUBLISH;
        end
      end
      PUBLISH: begin
        w_publish   = 1'b1;
        w_state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        // A level still held after done must not start a second conversion.
        if (!bus.next_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Working registers: capture and shift
  // --------------------------------------------------------------------------
  always_ff @(posedge vmm_clk or negedge rst_) begin
    if (!rst_) begin
      r_bin   <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_i_lat <= '0;
      r_j_lat <= '0;
    end else if (w_load) begin
      r_bin   <= w_mag;
      r_scr   <= '0;
      r_cnt   <= CNT_W'(W);
      r_i_lat <= bus.i_i;
      r_j_lat <= bus.j_i;
    end else if (w_shift) begin
      {r_scr, r_bin} <= w_shifted;
      r_cnt          <= r_cnt - CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Published outputs: change only in PUBLISH so the display never sees a
  // partially converted value.
  // --------------------------------------------------------------------------
  always_ff @(posedge vmm_clk or negedge rst_) begin
    if (!rst_) begin
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_bcd   <= '0;
      r_i_pub <= '0;
      r_j_pub <= '0;
    end else begin
      r_done <= w_publish;
      if (w_publish) begin
        r_valid <= 1'b1;
        r_bcd   <= r_scr;
        r_i_pub <= r_i_lat;
        r_j_pub <= r_j_lat;
      end
    end
  end

`ifdef VMM_BCD_SIGNED_EN
  always_ff @(posedge vmm_clk or negedge rst_) begin
    if (!rst_) begin
      r_sign_lat <= 1'b0;
      r_sign_pub <= 1'b0;
    end else begin
      if (w_load) begin
        r_sign_lat <= w_neg;
      end
      if (w_publish) begin
        r_sign_pub <= r_sign_lat;
      end
    end
  end

  assign bus.sign_o = r_sign_pub;
`else
  assign bus.sign_o = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  // Busy covers the shift cycles and the publish cycle, dropping on the
  // same edge that raises done.
  assign bus.busy_o  = (r_state == SHIFT) || (r_state == PUBLISH);
  assign bus.done_o  = r_done;
  assign bus.valid_o = r_valid;
  assign bus.bcd_o   = r_bcd;
  assign bus.i_o     = r_i_pub;
  assign bus.j_o     = r_j_pub;

endmodule : vmm_result_bcd

`default_nettype wire

// File: tb/tb_vmm_result_bcd.sv
// ============================================================================
// Module      : tb_vmm_result_bcd
// Description : Self-checking bench for vmm_result_bcd. Expected results are
//               queued when a request is driven and compared when done_o
//               pulses.
// Build option : VMM_BCD_SIGNED_EN - adds the signed conversion cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vmm_result_bcd;
  import vmm_pkg::*;

  localparam int W   = VMM_W;
  localparam int D   = VMM_D;
  localparam int IW  = VMM_IW;
  localparam int LAT = W + 2;

  typedef struct packed {
    logic [4*D-1:0] bcd;
    logic           sign;
    logic [IW-1:0]  i;
    logic [IW-1:0]  j;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vmm_result_bcd_if #(.W(W), .D(D), .IW(IW)) u_if ();

  vmm_result_bcd #(.W(W), .D(D), .IW(IW)) u_dut (
    .vmm_clk (clk),
    .rst_    (rst_n),
    .bus     (u_if)
  );

  exp_t r_sb[$];
  exp_t r_last;
  exp_t r_pop;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, sign/magnitude from the raw value.
  function automatic exp_t model(input logic [W-1:0] v, input logic [IW-1:0] ii,
                                 input logic [IW-1:0] jj);
    exp_t e;
    int   mag;
    mag    = int'({24'd0, v});
    e.sign = 1'b0;
`ifdef VMM_BCD_SIGNED_EN
    if (v[W-1]) begin
      mag    = (1 << W) - mag;
      e.sign = 1'b1;
    end
`endif
    e.bcd = '0;
    for (int k = 0; k < D; k++) begin
      e.bcd[4*k +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    e.i = ii;
    e.j = jj;
    return e;
  endfunction

  // Scoreboard: compare on every done pulse.
  always @(negedge clk) begin
    if (rst_n && u_if.done_o) begin
      n_done++;
      check("sb_nonempty_at_done", 32'(r_sb.size() > 0), 32'd1);
      if (r_sb.size() > 0) begin
        r_pop = r_sb.pop_front();
        check("bcd_o",   32'(u_if.bcd_o),   32'(r_pop.bcd));
        check("sign_o",  32'(u_if.sign_o),  32'(r_pop.sign));
        check("i_o",     32'(u_if.i_o),     32'(r_pop.i));
        check("j_o",     32'(u_if.j_o),     32'(r_pop.j));
        check("valid_o", 32'(u_if.valid_o), 32'd1);
        r_last = r_pop;
      end
    end
  end

  // One request: drive, optionally disturb val_i mid-shift, wait for done,
  // hold next_i for 'hold' extra cycles, then release.
  task automatic xfer(input logic [W-1:0] v, input logic [IW-1:0] ii,
                      input logic [IW-1:0] jj, input int hold,
                      input int chg_at, input logic [W-1:0] chg_v);
    int lat;
    @(negedge clk);
    u_if.val_i  = v;
    u_if.i_i    = ii;
    u_if.j_i    = jj;
    u_if.next_i = 1'b1;
    r_sb.push_back(model(v, ii, jj));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_in_shift", 32'(u_if.busy_o), 32'd1);
      if (lat == 4) check("bcd_held_mid_shift", 32'(u_if.bcd_o), 32'(r_last.bcd));
      if (lat == chg_at) u_if.val_i = chg_v;
    end while (!u_if.done_o && lat < 40);
    check("done_seen", 32'(u_if.done_o), 32'd1);
    check("latency", 32'(lat), 32'(LAT));
    check("busy_at_done", 32'(u_if.busy_o), 32'd0);
    repeat (hold) @(negedge clk);
    u_if.next_i = 1'b0;
    @(negedge clk);
  endtask

  int d0;

  initial begin
    r_last      = '0;
    rst_n       = 1'b0;
    u_if.next_i = 1'b0;
    u_if.val_i  = '0;
    u_if.i_i    = '0;
    u_if.j_i    = '0;
    repeat (3) @(negedge clk);
    check("rst_done",  32'(u_if.done_o),  32'd0);
    check("rst_busy",  32'(u_if.busy_o),  32'd0);
    check("rst_valid", 32'(u_if.valid_o), 32'd0);
    check("rst_bcd",   32'(u_if.bcd_o),   32'd0);
    check("rst_sign",  32'(u_if.sign_o),  32'd0);
    rst_n = 1'b1;

    xfer(8'd255, 5'd2, 5'd3, 0, 0, '0);
    d0 = n_done;
    xfer(8'd0, 5'd1, 5'd1, 0, 0, '0);
    check("zero_single_done", 32'(n_done - d0), 32'd1);
    xfer(8'd99, 5'd4, 5'd7, 0, 0, '0);

    // next_i held long after done: exactly one conversion.
    d0 = n_done;
    xfer(8'd37, 5'd9, 5'd10, 30, 0, '0);
    check("held_single_done", 32'(n_done - d0), 32'd1);
    check("held_not_busy", 32'(u_if.busy_o), 32'd0);

    // val_i changed during SHIFT is ignored.
    xfer(8'd10, 5'd5, 5'd6, 0, 3, 8'd200);

    // Reset in the middle of a conversion.
    d0 = n_done;
    @(negedge clk);
    u_if.val_i  = 8'd77;
    u_if.i_i    = 5'd12;
    u_if.j_i    = 5'd13;
    u_if.next_i = 1'b1;
    repeat (5) @(negedge clk);
    rst_n       = 1'b0;
    u_if.next_i = 1'b0;
    #1;
    check("midrst_busy",  32'(u_if.busy_o),  32'd0);
    check("midrst_valid", 32'(u_if.valid_o), 32'd0);
    check("midrst_bcd",   32'(u_if.bcd_o),   32'd0);
    check("midrst_i",     32'(u_if.i_o),     32'd0);
    check("midrst_j",     32'(u_if.j_o),     32'd0);
    r_last = '0;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(n_done - d0), 32'd0);
    rst_n = 1'b1;
    xfer(8'd123, 5'd31, 5'd0, 0, 0, '0);

    for (int k = 0; k < 6; k++) begin
      xfer(W'($urandom_range(0, 255)), IW'(k), IW'(31 - k), k % 2, 0, '0);
    end

`ifdef VMM_BCD_SIGNED_EN
    xfer(8'h80, 5'd1, 5'd2, 0, 0, '0);
    xfer(8'hFF, 5'd3, 5'd4, 0, 0, '0);
    xfer(8'd127, 5'd5, 5'd6, 0, 0, '0);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty_at_end", 32'(r_sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_vmm_result_bcd

`default_nettype wire
